// File: rtl/touch_pkg.sv
// Shared definitions for the touchpad scan path: channel codes, SPI command
// builder, scheduler state encoding and default calibration constants.
package touch_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned CMD_W  = 8;

  typedef logic [1:0] chan_t;

  localparam chan_t CH_X = 2'b10;
  localparam chan_t CH_Y = 2'b00;
  localparam chan_t CH_Z = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACC     = 3'd3,
    ST_NEXT    = 3'd4,
    ST_PUBLISH = 3'd5,
    ST_GAP     = 3'd6
  } state_e;

  localparam logic [DATA_W-1:0] DEF_Z_THRESH       = 12'h040;
  localparam logic [DATA_W-1:0] DEF_X_ADJ_MIN      = 12'h090;
  localparam logic [DATA_W-1:0] DEF_X_POST_ADJ_MAX = 12'h745;
  localparam logic [DATA_W-1:0] DEF_Y_ADJ_MIN      = 12'h060;
  localparam logic [DATA_W-1:0] DEF_Y_POST_ADJ_MAX = 12'h6F0;

  // Command byte: start bit, channel select, conversion-mode bit.
  function automatic logic [CMD_W-1:0] make_cmd(input chan_t ch);
    return {4'b0000, 1'b1, ch, 1'b1};
  endfunction

endpackage

// File: rtl/touch_adjust.sv
// Saturating offset/clamp for one axis.
//   avg_i : averaged raw axis value
//   adj_o : 0 below ADJ_MIN, else min(avg_i - ADJ_MIN, POST_ADJ_MAX) (combinational)
module touch_adjust
  import touch_pkg::*;
#(
  parameter logic [DATA_W-1:0] ADJ_MIN      = DEF_X_ADJ_MIN,
  parameter logic [DATA_W-1:0] POST_ADJ_MAX = DEF_X_POST_ADJ_MAX
) (
  input  logic [DATA_W-1:0] avg_i,
  output logic [DATA_W-1:0] adj_o
);

  logic [DATA_W-1:0] diff;

  always_comb begin
    diff = avg_i - ADJ_MIN;
    if (avg_i < ADJ_MIN) begin
      adj_o = '0;
    end else if (diff > POST_ADJ_MAX) begin
      adj_o = POST_ADJ_MAX;
    end else begin
      adj_o = diff;
    end
  end

endmodule

// File: rtl/touch_scan_scheduler.sv
// Repeated X/Y/Z scan sequencer with per-channel averaging and calibration.
//   cclk, rstb          : clock, async active-low reset
//   enable              : run continuous scans
//   xact_req/xact_cmd   : SPI transaction request and command byte
//   xact_done/xact_data : transaction completion pulse and 12-bit result
//   x, y, z, touched    : published calibrated coordinates and touch flag
//   sample_valid        : 1-cycle pulse on publish
//   busy                : scheduler not idle
module touch_scan_scheduler
  import touch_pkg::*;
#(
  parameter int unsigned       SAMPLES_LOG2   = 4,
  parameter int unsigned       GAP_CYCLES     = 1000,
  parameter logic [DATA_W-1:0] Z_THRESH       = DEF_Z_THRESH,
  parameter logic [DATA_W-1:0] X_ADJ_MIN      = DEF_X_ADJ_MIN,
  parameter logic [DATA_W-1:0] X_POST_ADJ_MAX = DEF_X_POST_ADJ_MAX,
  parameter logic [DATA_W-1:0] Y_ADJ_MIN      = DEF_Y_ADJ_MIN,
  parameter logic [DATA_W-1:0] Y_POST_ADJ_MAX = DEF_Y_POST_ADJ_MAX
) (
  input  logic              cclk,
  input  logic              rstb,
  input  logic              enable,
  output logic              xact_req,
  output logic [CMD_W-1:0]  xact_cmd,
  input  logic              xact_done,
  input  logic [DATA_W-1:0] xact_data,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] z,
  output logic              touched,
  output logic              sample_valid,
  output logic              busy
);

  localparam int unsigned ACC_W = DATA_W + SAMPLES_LOG2;
  localparam int unsigned CNT_W = SAMPLES_LOG2;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e            state_q, state_d;
  chan_t             chan_q, chan_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] avg_x_q, avg_x_d, avg_y_q, avg_y_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic              touched_q, touched_d, valid_q, valid_d;
  logic              req_q, req_d, busy_q, busy_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;

  logic [DATA_W-1:0] avg_c, adj_x_c, adj_y_c;
  logic              last_sample_c;

  assign avg_c         = DATA_W'(acc_q >> SAMPLES_LOG2);
  assign last_sample_c = &cnt_q;

  touch_adjust #(.ADJ_MIN(X_ADJ_MIN), .POST_ADJ_MAX(X_POST_ADJ_MAX)) u_adj_x (
    .avg_i (avg_x_q),
    .adj_o (adj_x_c)
  );

  touch_adjust #(.ADJ_MIN(Y_ADJ_MIN), .POST_ADJ_MAX(Y_POST_ADJ_MAX)) u_adj_y (
    .avg_i (avg_y_q),
    .adj_o (adj_y_c)
  );

  // State register and datapath registers.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      chan_q    <= CH_X;
      cnt_q     <= '0;
      acc_q     <= '0;
      avg_x_q   <= '0;
      avg_y_q   <= '0;
      gap_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      touched_q <= 1'b0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      avg_x_q   <= avg_x_d;
      avg_y_q   <= avg_y_d;
      gap_q     <= gap_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      touched_q <= touched_d;
      valid_q   <= valid_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      cmd_q     <= cmd_d;
    end
  end

  // Next-state logic; a dropped enable is honoured only between transactions.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (enable) state_d = ST_REQ;
      ST_REQ:     state_d = ST_WAIT;
      ST_WAIT:    if (xact_done) state_d = ST_ACC;
      ST_ACC: begin
        if (!enable)           state_d = ST_IDLE;
        else if (last_sample_c) state_d = ST_NEXT;
        else                   state_d = ST_REQ;
      end
      ST_NEXT: begin
        if (!enable)            state_d = ST_IDLE;
        else if (chan_q == CH_Z) state_d = ST_PUBLISH;
        else                    state_d = ST_REQ;
      end
      ST_PUBLISH: state_d = ST_GAP;
      ST_GAP:     if (gap_q == '0) state_d = enable ? ST_REQ : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    chan_d    = chan_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    avg_x_d   = avg_x_q;
    avg_y_d   = avg_y_q;
    gap_d     = gap_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    touched_d = touched_q;
    valid_d   = 1'b0;
    req_d     = (state_d == ST_REQ) || (state_d == ST_WAIT);
    busy_d    = (state_d != ST_IDLE);
    cmd_d     = cmd_q;

    case (state_q)
      ST_IDLE: begin
        chan_d = CH_X;
        cnt_d  = '0;
        acc_d  = '0;
      end
      ST_WAIT: begin
        if (xact_done) acc_d = acc_q + ACC_W'(xact_data);
      end
      ST_ACC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!enable) begin
          chan_d = CH_X;
          cnt_d  = '0;
          acc_d  = '0;
        end
      end
      ST_NEXT: begin
        acc_d = '0;
        cnt_d = '0;
        if (!enable) begin
          chan_d = CH_X;
        end else if (chan_q == CH_X) begin
          avg_x_d = avg_c;
          chan_d  = CH_Y;
        end else if (chan_q == CH_Y) begin
          avg_y_d = avg_c;
          chan_d  = CH_Z;
        end else begin
          // Publish lands with sample_valid; x/y only follow a touched z.
          z_d       = avg_c;
          touched_d = (avg_c >= Z_THRESH);
          valid_d   = 1'b1;
          chan_d    = CH_X;
          if (avg_c >= Z_THRESH) begin
            x_d = adj_x_c;
            y_d = adj_y_c;
          end
        end
      end
      ST_PUBLISH: gap_d = GAP_W'(GAP_CYCLES - 1);
      ST_GAP: begin
        if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
      end
      default: ;
    endcase

    // Command only changes when a new request starts, so it is stable during req.
    if (state_d == ST_REQ) cmd_d = make_cmd(chan_d);
  end

  assign xact_req     = req_q;
  assign xact_cmd     = cmd_q;
  assign x            = x_q;
  assign y            = y_q;
  assign z            = z_q;
  assign touched      = touched_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule
